// File: rtl/lc3_pkg.sv
// lc3_pkg: shared definitions for the LC-3 control unit.
//   state_t   - FSM states, encoded as LC-3 state numbers (S_INIT reports 63)
//   OP_*      - IR[15:12] opcode constants
//   PCMUX_*, ADDR1_*, ADDR2_* - datapath mux select encodings
//   ctrl_t    - control word produced by lc3_ctrl_rom
package lc3_pkg;

    typedef enum logic [5:0] {
        S_0    = 6'd0,
        S_1    = 6'd1,
        S_2    = 6'd2,
        S_3    = 6'd3,
        S_5    = 6'd5,
        S_9    = 6'd9,
        S_12   = 6'd12,
        S_14   = 6'd14,
        S_16   = 6'd16,
        S_18   = 6'd18,
        S_22   = 6'd22,
        S_23   = 6'd23,
        S_25   = 6'd25,
        S_27   = 6'd27,
        S_32   = 6'd32,
        S_33   = 6'd33,
        S_35   = 6'd35,
        S_INIT = 6'd63
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic       ADDR1_PC    = 1'b0;
    localparam logic       ADDR1_BASER = 1'b1;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_pc;
        logic       ld_reg;
        logic       ld_cc;
        logic       ld_ben;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic       mio_en;
        logic       r_w;
        logic       illegal;
    } ctrl_t;

    // Opcodes this control unit implements; everything else is ILLEGAL.
    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_BR, OP_ADD, OP_LD, OP_ST,
            OP_AND, OP_NOT, OP_JMP, OP_LEA: op_legal = 1'b1;
            default:                        op_legal = 1'b0;
        endcase
    endfunction

    // Dispatch target from state 32; unsupported opcodes refetch at 18.
    function automatic state_t decode_op(input logic [3:0] op);
        case (op)
            OP_ADD:  decode_op = S_1;
            OP_AND:  decode_op = S_5;
            OP_NOT:  decode_op = S_9;
            OP_BR:   decode_op = S_0;
            OP_JMP:  decode_op = S_12;
            OP_LEA:  decode_op = S_14;
            OP_LD:   decode_op = S_2;
            OP_ST:   decode_op = S_3;
            default: decode_op = S_18;
        endcase
    endfunction

endpackage

// File: rtl/lc3_ctrl_rom.sv
// lc3_ctrl_rom: combinational state-to-control-word decode.
//   i_state  - current FSM state
//   i_mem_r  - memory ready (qualifies LD_MDR during read waits)
//   i_opcode - IR[15:12] (qualifies ILLEGAL in state 32)
//   o_ctrl   - load enables, bus gates, mux selects, memory controls
module lc3_ctrl_rom
    import lc3_pkg::*;
(
    input  state_t     i_state,
    input  logic       i_mem_r,
    input  logic [3:0] i_opcode,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_18: begin
                o_ctrl.gate_pc = 1'b1;
                o_ctrl.ld_mar  = 1'b1;
                o_ctrl.ld_pc   = 1'b1;
                o_ctrl.pcmux   = PCMUX_INC;
            end
            // Read wait: MDR captures only in the cycle memory reports ready.
            S_33, S_25: begin
                o_ctrl.mio_en = 1'b1;
                o_ctrl.r_w    = 1'b0;
                o_ctrl.ld_mdr = i_mem_r;
            end
            S_35: begin
                o_ctrl.gate_mdr = 1'b1;
                o_ctrl.ld_ir    = 1'b1;
            end
            S_32: begin
                o_ctrl.ld_ben  = 1'b1;
                o_ctrl.illegal = ~op_legal(i_opcode);
            end
            S_1, S_5, S_9: begin
                o_ctrl.gate_alu = 1'b1;
                o_ctrl.ld_reg   = 1'b1;
                o_ctrl.ld_cc    = 1'b1;
            end
            S_22: begin
                o_ctrl.ld_pc    = 1'b1;
                o_ctrl.pcmux    = PCMUX_ADDER;
                o_ctrl.addr1mux = ADDR1_PC;
                o_ctrl.addr2mux = ADDR2_OFF9;
            end
            S_12: begin
                o_ctrl.ld_pc    = 1'b1;
                o_ctrl.pcmux    = PCMUX_ADDER;
                o_ctrl.addr1mux = ADDR1_BASER;
                o_ctrl.addr2mux = ADDR2_ZERO;
            end
            S_14: begin
                o_ctrl.gate_marmux = 1'b1;
                o_ctrl.ld_reg      = 1'b1;
                o_ctrl.addr1mux    = ADDR1_PC;
                o_ctrl.addr2mux    = ADDR2_OFF9;
            end
            S_2, S_3: begin
                o_ctrl.gate_marmux = 1'b1;
                o_ctrl.ld_mar      = 1'b1;
                o_ctrl.addr1mux    = ADDR1_PC;
                o_ctrl.addr2mux    = ADDR2_OFF9;
            end
            S_27: begin
                o_ctrl.gate_mdr = 1'b1;
                o_ctrl.ld_reg   = 1'b1;
                o_ctrl.ld_cc    = 1'b1;
            end
            // ALU passes SR onto the bus so MDR picks up the store data.
            S_23: begin
                o_ctrl.ld_mdr   = 1'b1;
                o_ctrl.gate_alu = 1'b1;
            end
            S_16: begin
                o_ctrl.mio_en = 1'b1;
                o_ctrl.r_w    = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/lc3_control.sv
// lc3_control: LC-3 microsequencer (subset: ADD AND NOT BR JMP LEA LD ST).
//   CLK, RST_N          - rising-edge clock, async active-low reset
//   IR, BEN, MEM_R      - instruction, latched branch enable, memory ready
//   LD_*                - register load enables
//   GATE_*              - bus drivers (one-hot or none)
//   PCMUX, ADDR1MUX, ADDR2MUX - address/PC mux selects
//   MIO_EN, R_W         - memory enable / write strobe
//   ILLEGAL             - unsupported opcode seen in decode state 32
//   STATE               - current LC-3 state number (63 in reset)
module lc3_control
    import lc3_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] IR,
    input  logic        BEN,
    input  logic        MEM_R,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_PC,
    output logic        LD_REG,
    output logic        LD_CC,
    output logic        LD_BEN,
    output logic        GATE_PC,
    output logic        GATE_MDR,
    output logic        GATE_ALU,
    output logic        GATE_MARMUX,
    output logic [1:0]  PCMUX,
    output logic        ADDR1MUX,
    output logic [1:0]  ADDR2MUX,
    output logic        MIO_EN,
    output logic        R_W,
    output logic        ILLEGAL,
    output logic [5:0]  STATE
);

    state_t     r_state;
    state_t     w_next;
    ctrl_t      w_ctrl;
    logic [3:0] w_opcode;
    logic       w_unused_ir;

    assign w_opcode    = IR[15:12];
    assign w_unused_ir = ^IR[11:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT: w_next = S_18;
            S_18:   w_next = S_33;
            S_33:   w_next = MEM_R ? S_35 : S_33;
            S_35:   w_next = S_32;
            S_32:   w_next = decode_op(w_opcode);
            S_1, S_5, S_9, S_14, S_22, S_12, S_27:
                    w_next = S_18;
            S_0:    w_next = BEN ? S_22 : S_18;
            S_2:    w_next = S_25;
            S_25:   w_next = MEM_R ? S_27 : S_25;
            S_3:    w_next = S_23;
            S_23:   w_next = S_16;
            S_16:   w_next = MEM_R ? S_18 : S_16;
            default: w_next = S_18;
        endcase
    end

    lc3_ctrl_rom u_rom (
        .i_state  (r_state),
        .i_mem_r  (MEM_R),
        .i_opcode (w_opcode),
        .o_ctrl   (w_ctrl)
    );

    assign LD_MAR      = w_ctrl.ld_mar;
    assign LD_MDR      = w_ctrl.ld_mdr;
    assign LD_IR       = w_ctrl.ld_ir;
    assign LD_PC       = w_ctrl.ld_pc;
    assign LD_REG      = w_ctrl.ld_reg;
    assign LD_CC       = w_ctrl.ld_cc;
    assign LD_BEN      = w_ctrl.ld_ben;
    assign GATE_PC     = w_ctrl.gate_pc;
    assign GATE_MDR    = w_ctrl.gate_mdr;
    assign GATE_ALU    = w_ctrl.gate_alu;
    assign GATE_MARMUX = w_ctrl.gate_marmux;
    assign PCMUX       = w_ctrl.pcmux;
    assign ADDR1MUX    = w_ctrl.addr1mux;
    assign ADDR2MUX    = w_ctrl.addr2mux;
    assign MIO_EN      = w_ctrl.mio_en;
    assign R_W         = w_ctrl.r_w;
    assign ILLEGAL     = w_ctrl.illegal;
    assign STATE       = r_state;

endmodule

// File: tb/tb_lc3_control.sv
// tb_lc3_control: scoreboard bench for lc3_control. Each test queues the
// expected state sequence (with the MEM_R value to drive in that cycle),
// then walks the queue cycle by cycle comparing STATE and the full
// control vector against an independent per-state reference.
module tb_lc3_control;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] IR;
    logic        BEN;
    logic        MEM_R;
    logic        LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_BEN;
    logic        GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX;
    logic [1:0]  PCMUX;
    logic        ADDR1MUX;
    logic [1:0]  ADDR2MUX;
    logic        MIO_EN, R_W, ILLEGAL;
    logic [5:0]  STATE;

    lc3_control dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .IR          (IR),
        .BEN         (BEN),
        .MEM_R       (MEM_R),
        .LD_MAR      (LD_MAR),
        .LD_MDR      (LD_MDR),
        .LD_IR       (LD_IR),
        .LD_PC       (LD_PC),
        .LD_REG      (LD_REG),
        .LD_CC       (LD_CC),
        .LD_BEN      (LD_BEN),
        .GATE_PC     (GATE_PC),
        .GATE_MDR    (GATE_MDR),
        .GATE_ALU    (GATE_ALU),
        .GATE_MARMUX (GATE_MARMUX),
        .PCMUX       (PCMUX),
        .ADDR1MUX    (ADDR1MUX),
        .ADDR2MUX    (ADDR2MUX),
        .MIO_EN      (MIO_EN),
        .R_W         (R_W),
        .ILLEGAL     (ILLEGAL),
        .STATE       (STATE)
    );

    always #5 CLK = ~CLK;

    logic [18:0] w_act;
    assign w_act = {LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_BEN,
                    GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX,
                    PCMUX, ADDR1MUX, ADDR2MUX, MIO_EN, R_W, ILLEGAL};

    typedef struct {
        logic [5:0] st;
        logic       mr;
    } step_t;

    step_t       sb[$];
    step_t       e;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Reference control vector, built signal-by-signal from the state list.
    function automatic logic [18:0] exp_ctl(input logic [5:0] st, input logic mr,
                                            input logic [15:0] ir);
        logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben;
        logic       g_pc, g_mdr, g_alu, g_mm, a1, mio, rw, ill;
        logic [1:0] pcm, a2;
        logic [3:0] op;
        op     = ir[15:12];
        ld_mar = (st == 18) || (st == 2) || (st == 3);
        ld_mdr = (((st == 33) || (st == 25)) && mr) || (st == 23);
        ld_ir  = (st == 35);
        ld_pc  = (st == 18) || (st == 22) || (st == 12);
        ld_reg = (st == 1) || (st == 5) || (st == 9) || (st == 14) || (st == 27);
        ld_cc  = (st == 1) || (st == 5) || (st == 9) || (st == 27);
        ld_ben = (st == 32);
        g_pc   = (st == 18);
        g_mdr  = (st == 35) || (st == 27);
        g_alu  = (st == 1) || (st == 5) || (st == 9) || (st == 23);
        g_mm   = (st == 14) || (st == 2) || (st == 3);
        pcm    = ((st == 22) || (st == 12)) ? 2'b10 : 2'b00;
        a1     = (st == 12);
        a2     = ((st == 22) || (st == 14) || (st == 2) || (st == 3)) ? 2'b10 : 2'b00;
        mio    = (st == 33) || (st == 25) || (st == 16);
        rw     = (st == 16);
        ill    = (st == 32) && !(op == 4'h0 || op == 4'h1 || op == 4'h2 || op == 4'h3 ||
                                 op == 4'h5 || op == 4'h9 || op == 4'hC || op == 4'hE);
        return {ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben,
                g_pc, g_mdr, g_alu, g_mm, pcm, a1, a2, mio, rw, ill};
    endfunction

    task automatic push(input logic [5:0] st, input logic mr);
        step_t s;
        s.st = st;
        s.mr = mr;
        sb.push_back(s);
    endtask

    task automatic push_fetch(input logic [5:0] dispatch);
        push(6'd18, 1'b1);
        push(6'd33, 1'b1);
        push(6'd35, 1'b1);
        push(6'd32, 1'b1);
        push(dispatch, 1'b1);
    endtask

    task automatic test_reset;
        RST_N = 1'b0; IR = 16'h0000; BEN = 1'b0; MEM_R = 1'b1;
        #12;
        n_total++;
        if (STATE !== 6'd63) $display("FAIL reset_state: got %0d want 63", STATE);
        else n_pass++;
        n_total++;
        if (w_act !== 19'd0) $display("FAIL reset_outputs: got %h want 0", w_act);
        else n_pass++;
        @(posedge CLK); #1;
        n_total++;
        if (STATE !== 6'd63) $display("FAIL reset_hold: got %0d want 63", STATE);
        else n_pass++;
        RST_N = 1'b1;
    endtask

    task automatic test_add;
        IR = 16'h1042;
        push(6'd63, 1'b1);
        push_fetch(6'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            MEM_R = e.mr; #2;
            n_total++;
            if (STATE !== e.st) $display("FAIL add_state: got %0d want %0d", STATE, e.st);
            else n_pass++;
            n_total++;
            if (w_act !== exp_ctl(e.st, e.mr, IR))
                $display("FAIL add_ctl: st %0d got %h want %h", e.st, w_act, exp_ctl(e.st, e.mr, IR));
            else n_pass++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_branch;
        for (int b = 1; b >= 0; b--) begin
            IR  = 16'h0E05;
            BEN = b[0];
            push_fetch(6'd0);
            if (b == 1) push(6'd22, 1'b1);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                MEM_R = e.mr; #2;
                n_total++;
                if (STATE !== e.st) $display("FAIL br_state: ben %0d got %0d want %0d", b, STATE, e.st);
                else n_pass++;
                n_total++;
                if (w_act !== exp_ctl(e.st, e.mr, IR))
                    $display("FAIL br_ctl: st %0d got %h want %h", e.st, w_act, exp_ctl(e.st, e.mr, IR));
                else n_pass++;
                @(posedge CLK); #1;
            end
        end
        BEN = 1'b0;
    endtask

    task automatic test_decode;
        logic [15:0] irs[4] = '{16'h5000, 16'h9000, 16'hC000, 16'hE000};
        logic [5:0]  sts[4] = '{6'd5, 6'd9, 6'd12, 6'd14};
        for (int i = 0; i < 4; i++) begin
            IR = irs[i];
            push_fetch(sts[i]);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                MEM_R = e.mr; #2;
                n_total++;
                if (STATE !== e.st) $display("FAIL dec_state: ir %h got %0d want %0d", IR, STATE, e.st);
                else n_pass++;
                n_total++;
                if (w_act !== exp_ctl(e.st, e.mr, IR))
                    $display("FAIL dec_ctl: st %0d got %h want %h", e.st, w_act, exp_ctl(e.st, e.mr, IR));
                else n_pass++;
                @(posedge CLK); #1;
            end
        end
    endtask

    task automatic test_illegal;
        IR = 16'hD000;
        push(6'd18, 1'b1);
        push(6'd33, 1'b1);
        push(6'd35, 1'b1);
        push(6'd32, 1'b1);
        push(6'd18, 1'b0);
        push(6'd33, 1'b1);
        push(6'd35, 1'b1);
        IR = 16'hD000;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            MEM_R = e.mr; #2;
            n_total++;
            if (STATE !== e.st) $display("FAIL ill_state: got %0d want %0d", STATE, e.st);
            else n_pass++;
            n_total++;
            if (w_act !== exp_ctl(e.st, e.mr, IR))
                $display("FAIL ill_ctl: st %0d got %h want %h", e.st, w_act, exp_ctl(e.st, e.mr, IR));
            else n_pass++;
            @(posedge CLK); #1;
        end
        // Finish this fetch as a legal ADD so the next test starts at 18.
        IR = 16'h1042;
        push(6'd32, 1'b1);
        push(6'd1, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            MEM_R = e.mr; #2;
            n_total++;
            if (STATE !== e.st) $display("FAIL ill_tail_state: got %0d want %0d", STATE, e.st);
            else n_pass++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_ld;
        IR = 16'h2403;
        push_fetch(6'd2);
        push(6'd25, 1'b0);
        push(6'd25, 1'b0);
        push(6'd25, 1'b0);
        push(6'd25, 1'b1);
        push(6'd27, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            MEM_R = e.mr; #2;
            n_total++;
            if (STATE !== e.st) $display("FAIL ld_state: got %0d want %0d", STATE, e.st);
            else n_pass++;
            n_total++;
            if (w_act !== exp_ctl(e.st, e.mr, IR))
                $display("FAIL ld_ctl: st %0d got %h want %h", e.st, w_act, exp_ctl(e.st, e.mr, IR));
            else n_pass++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_st;
        IR = 16'h3403;
        push(6'd18, 1'b0);
        push(6'd33, 1'b0);
        push(6'd33, 1'b1);
        push(6'd35, 1'b1);
        push(6'd32, 1'b1);
        push(6'd3, 1'b1);
        push(6'd23, 1'b1);
        push(6'd16, 1'b0);
        push(6'd16, 1'b0);
        push(6'd16, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            MEM_R = e.mr; #2;
            n_total++;
            if (STATE !== e.st) $display("FAIL st_state: got %0d want %0d", STATE, e.st);
            else n_pass++;
            n_total++;
            if (w_act !== exp_ctl(e.st, e.mr, IR))
                $display("FAIL st_ctl: st %0d got %h want %h", e.st, w_act, exp_ctl(e.st, e.mr, IR));
            else n_pass++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_midwait;
        IR = 16'h1042;
        push(6'd18, 1'b0);
        push(6'd33, 1'b0);
        push(6'd33, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            MEM_R = e.mr; #2;
            n_total++;
            if (STATE !== e.st) $display("FAIL rmw_state: got %0d want %0d", STATE, e.st);
            else n_pass++;
            @(posedge CLK); #1;
        end
        // Still waiting in 33; reset mid-cycle, away from any clock edge.
        MEM_R = 1'b1; #2;
        RST_N = 1'b0; #1;
        n_total++;
        if (STATE !== 6'd63) $display("FAIL rmw_async: got %0d want 63", STATE);
        else n_pass++;
        n_total++;
        if (w_act !== 19'd0) $display("FAIL rmw_outputs: got %h want 0", w_act);
        else n_pass++;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        push(6'd63, 1'b1);
        push_fetch(6'd1);
        push(6'd18, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            MEM_R = e.mr; #2;
            n_total++;
            if (STATE !== e.st) $display("FAIL rmw_restart: got %0d want %0d", STATE, e.st);
            else n_pass++;
            n_total++;
            if (w_act !== exp_ctl(e.st, e.mr, IR))
                $display("FAIL rmw_ctl: st %0d got %h want %h", e.st, w_act, exp_ctl(e.st, e.mr, IR));
            else n_pass++;
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_branch;
        test_decode;
        test_illegal;
        test_ld;
        test_st;
        test_reset_midwait;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time exceeded, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
